// File: rtl/disp_write_sequencer.sv
// Write-side sequencer for the character display buffer: arbitrates two character
// ports and a clear-screen request, then strobes dataReady with fixed setup/high/low spacing.
module disp_write_sequencer #(
  parameter int ASCII_WIDTH = 8,
  parameter int COLOR_WIDTH = 4,
  parameter int GRID_ROW    = 5,
  parameter int GRID_COL    = 10,
  parameter int PULSE_HI    = 2,
  parameter int PULSE_LO    = 2
) (
  input  logic                   clk_pix,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ASCII_WIDTH-1:0] a_ascii,
  input  logic [COLOR_WIDTH-1:0] a_colorF,
  input  logic [COLOR_WIDTH-1:0] a_colorB,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ASCII_WIDTH-1:0] b_ascii,
  input  logic [COLOR_WIDTH-1:0] b_colorF,
  input  logic [COLOR_WIDTH-1:0] b_colorB,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   busy,
  output logic                   dataReady,
  output logic [ASCII_WIDTH-1:0] ascii,
  output logic [COLOR_WIDTH-1:0] colorIndexF,
  output logic [COLOR_WIDTH-1:0] colorIndexB
);

  localparam int CELLS  = GRID_ROW * GRID_COL;
  localparam int CELL_W = $clog2(CELLS + 1);
  localparam int MAXP   = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int CNT_W  = $clog2(MAXP + 1);

  localparam logic [CNT_W-1:0]       HI_LOAD   = CNT_W'(PULSE_HI - 1);
  localparam logic [CNT_W-1:0]       LO_LOAD   = CNT_W'(PULSE_LO - 1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CELL_W-1:0]      CELL_ZERO = {CELL_W{1'b0}};
  localparam logic [CELL_W-1:0]      CELL_ONE  = CELL_W'(1);
  localparam logic [CELL_W-1:0]      LAST_CELL = CELL_W'(CELLS - 1);
  localparam logic [ASCII_WIDTH-1:0] SPACE     = ASCII_WIDTH'(32);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HI, S_LO} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CELL_W-1:0]      cell_q, cell_d;
  logic                   clr_pend_q, clr_pend_d;
  logic                   clr_mode_q, clr_mode_d;
  logic                   last_b_q, last_b_d;
  logic                   dr_q, dr_d;
  logic [ASCII_WIDTH-1:0] ascii_q, ascii_d;
  logic [COLOR_WIDTH-1:0] colf_q, colf_d;
  logic [COLOR_WIDTH-1:0] colb_q, colb_d;

  logic idle_s;
  logic open_s;
  logic grant_a_s;

  assign idle_s    = (state_q == S_IDLE);
  assign open_s    = !rst && idle_s && !clr_pend_q;
  // A wins unless B is also valid and A was the last port served.
  assign grant_a_s = a_valid && (!b_valid || last_b_q);
  assign a_ready   = open_s && grant_a_s;
  assign b_ready   = open_s && b_valid && !grant_a_s;

  assign busy        = !idle_s;
  assign clr_busy    = clr_pend_q || clr_mode_q;
  assign dataReady   = dr_q;
  assign ascii       = ascii_q;
  assign colorIndexF = colf_q;
  assign colorIndexB = colb_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cell_d     = cell_q;
    clr_pend_d = clr_pend_q || clr_req;
    clr_mode_d = clr_mode_q;
    last_b_d   = last_b_q;
    ascii_d    = ascii_q;
    colf_d     = colf_q;
    colb_d     = colb_q;
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          // A request arriving on this very edge keeps the flag for a follow-up clear.
          clr_pend_d = clr_req;
          clr_mode_d = 1'b1;
          cell_d     = CELL_ZERO;
          ascii_d    = SPACE;
          colf_d     = a_colorF;
          colb_d     = a_colorB;
          state_d    = S_SETUP;
        end else if (a_ready) begin
          ascii_d  = a_ascii;
          colf_d   = a_colorF;
          colb_d   = a_colorB;
          last_b_d = 1'b0;
          state_d  = S_SETUP;
        end else if (b_ready) begin
          ascii_d  = b_ascii;
          colf_d   = b_colorF;
          colb_d   = b_colorB;
          last_b_d = 1'b1;
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_HI;
        cnt_d   = HI_LOAD;
      end
      S_HI: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_LO;
          cnt_d   = LO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_LO: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (clr_mode_q && (cell_q != LAST_CELL)) begin
          cell_d  = cell_q + CELL_ONE;
          state_d = S_SETUP;
        end else begin
          cell_d     = CELL_ZERO;
          clr_mode_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dr_d = (state_d == S_HI);
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      cell_q     <= CELL_ZERO;
      clr_pend_q <= 1'b0;
      clr_mode_q <= 1'b0;
      last_b_q   <= 1'b1;
      dr_q       <= 1'b0;
      ascii_q    <= {ASCII_WIDTH{1'b0}};
      colf_q     <= {COLOR_WIDTH{1'b0}};
      colb_q     <= {COLOR_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cell_q     <= cell_d;
      clr_pend_q <= clr_pend_d;
      clr_mode_q <= clr_mode_d;
      last_b_q   <= last_b_d;
      dr_q       <= dr_d;
      ascii_q    <= ascii_d;
      colf_q     <= colf_d;
      colb_q     <= colb_d;
    end
  end

endmodule

// File: doc/disp_write_sequencer.md
# disp_write_sequencer

Write-side controller for the character display buffer. Arbitrates two character sources (port A: keyboard decoder, port B: host/UART text path) and a clear-screen request, then drives the buffer's `dataReady`, `ascii`, `colorIndexF` and `colorIndexB` inputs. `dataReady` acts as the buffer's write clock, so the sequencer guarantees setup, pulse-high and pulse-low spacing in `clk_pix` cycles.

## Interface
Parameters:
- `ASCII_WIDTH`, 8, character code width.
- `COLOR_WIDTH`, 4, width of each colour index.
- `GRID_ROW`, 5, display rows.
- `GRID_COL`, 10, display columns.
- `PULSE_HI`, 2, `dataReady` high time in cycles; must be ≥1.
- `PULSE_LO`, 2, `dataReady` low time after each pulse in cycles; must be ≥1.

Ports:
- `clk_pix` in 1: pixel clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `a_valid` in 1: port A has a character.
- `a_ready` out 1: port A transfer accepted this cycle.
- `a_ascii` in ASCII_WIDTH: port A character.
- `a_colorF` in COLOR_WIDTH: port A foreground colour.
- `a_colorB` in COLOR_WIDTH: port A background colour.
- `b_valid`, `b_ready`, `b_ascii`, `b_colorF`, `b_colorB`: port B, identical to port A.
- `clr_req` in 1: single-cycle clear-screen request.
- `clr_busy` out 1: clear pending or in progress.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `dataReady` out 1: write strobe to the buffer. Registered.
- `ascii` out ASCII_WIDTH: character to the buffer. Registered.
- `colorIndexF` out COLOR_WIDTH: foreground colour to the buffer. Registered.
- `colorIndexB` out COLOR_WIDTH: background colour to the buffer. Registered.

## Operation
- FSM states:
  - IDLE
  - SETUP: data stable, `dataReady` 0, exactly 1 cycle.
  - HI: `dataReady` 1 for PULSE_HI cycles.
  - LO: `dataReady` 0 for PULSE_LO cycles.
- One down-counter, sized for max(PULSE_HI, PULSE_LO), times the HI and LO states.
- Clear-pending flag:
  - Set by `clr_req` in any state.
  - Multiple requests while pending merge into one clear.
  - Cleared when the clear is accepted.
- IDLE priority:
  1. Clear pending. Enter clear mode and go to SETUP with `ascii` = 8'd32. Colours load from `a_colorF`/`a_colorB` and are held for the whole clear.
  2. Otherwise, character ports under round-robin arbitration.
- Round-robin:
  - `last_grant` register resets to B, so A wins the first contention.
  - If both ports are valid, the port not granted last wins.
  - If one port is valid, it wins regardless of `last_grant`.
- Handshake:
  - `x_ready` is combinational. It is high only in IDLE, with no clear pending, for the granted port with `x_valid` high.
  - A transfer occurs on a clock edge where `x_valid && x_ready`.
  - At that edge, `ascii` and the colour outputs load, `last_grant` updates, and the FSM goes to SETUP.
  - Sources hold their data until ready; `x_ready` is never high without `x_valid`.
- Character codes pass through unmodified, including cursor and edit codes (0x11–0x14, 0x0D, 0x7F).
- Clear mode:
  - Issues exactly GRID_ROW*GRID_COL space writes through SETUP/HI/LO, using a cell counter of width $clog2(GRID_ROW*GRID_COL+1).
  - After the last LO, the FSM returns to IDLE, `clr_busy` drops, and the cursor is back at its starting cell.
  - Both ready outputs stay 0 for the whole clear.
- `clr_busy` = pending flag OR clear mode.

## Timing
- Transfer accepted at edge T:
  - `ascii` and colours valid after T.
  - `dataReady` rises at T+1.
  - `dataReady` falls at T+1+PULSE_HI.
  - FSM returns to IDLE at T+1+PULSE_HI+PULSE_LO.
- Earliest next accept is at edge T+2+PULSE_HI+PULSE_LO, i.e. 6 cycles with default parameters.
- `ascii` and colours change only on accept edges, or between clear writes (value unchanged in that case). They never change while `dataReady` is high or in the cycle before it rises.
- Full clear lasts GRID_ROW*GRID_COL*(1+PULSE_HI+PULSE_LO) cycles from accept, plus the IDLE entry cycle. With defaults that is 50×5 = 250.
- `clr_req` arriving during a character write: the pending flag sets, the current write completes normally, and the clear starts at the next IDLE cycle ahead of any valid port.
- `clr_req` during clear mode: sets pending, so a second full clear follows.
- Reset values (asynchronous, immediate on `rst` high):
  - `dataReady`, `ascii`, `colorIndexF`, `colorIndexB`, `a_ready`, `b_ready`, `busy`, `clr_busy` = 0.
  - FSM = IDLE; counters = 0; `last_grant` = B.
- Reset during HI truncates the pulse asynchronously. The rising edge already issued is not retracted. On release, the first accept is possible in the first cycle.

## Test plan
- Single A write: `a_valid`=1, `a_ascii`=0x41, F=3, B=0 → `a_ready` high for 1 cycle, `dataReady` high cycles 1–2 after accept, `ascii`=0x41 stable from accept edge to end of LO; next accept no earlier than cycle 6.
- Contention: A and B valid continuously with 0x41 and 0x42 → outputs alternate 0x41, 0x42, 0x41… (A first after reset), one write per 6 cycles, no port starved.
- Clear during write: `clr_req` pulse 1 cycle after an A accept with 0x58 → 0x58 pulse completes, then exactly 50 pulses of 0x20 with port-A colours, `clr_busy` high throughout, ready outputs 0; after clear, a pending B write is accepted.
- Merged clears: three `clr_req` pulses within the first 10 cycles of a clear → exactly 100 space writes total.
- Pass-through: B sends 0x7F, 0x0D, 0x14 → three strobes with identical codes, timing as for ordinary characters.
- Reset mid-pulse: assert `rst` in the first HI cycle → `dataReady` 0 immediately, all outputs 0; after release, A with 0x31 is accepted in the first cycle and strobed normally.
